// File: rtl/hud_bcd_converter.sv
// Once-per-frame binary-to-BCD converter for the HUD: snapshots Score/Level/Lives
// on the frame strobe and runs a serial double-dabble engine over them in turn.
module hud_bcd_converter (
    input  logic        Clk,
    input  logic        Reset_n,
    input  logic [9:0]  DrawX,
    input  logic [9:0]  DrawY,
    input  logic [15:0] Score,
    input  logic [7:0]  Level,
    input  logic [7:0]  Lives,
    output logic [19:0] ScoreBCD,
    output logic [11:0] LevelBCD,
    output logic [11:0] LivesBCD,
    output logic [2:0]  ScoreDigits,
    output logic        bcd_valid,
    output logic        update_pulse,
    output logic        busy
);

    localparam int unsigned SCORE_W = 16;
    localparam int unsigned LEVEL_W = 8;
    localparam int unsigned LIVES_W = 8;
    localparam int unsigned SNAP_W  = SCORE_W + LEVEL_W + LIVES_W;
    localparam int unsigned WORK_W  = 20;
    localparam int unsigned CNT_W   = 4;

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_SCORE  = 3'd1;
    localparam logic [2:0] S_LEVEL  = 3'd2;
    localparam logic [2:0] S_LIVES  = 3'd3;
    localparam logic [2:0] S_UPDATE = 3'd4;

    localparam logic [CNT_W-1:0] SCORE_LAST = CNT_W'(SCORE_W - 1);
    localparam logic [CNT_W-1:0] SHORT_LAST = CNT_W'(LEVEL_W - 1);

    logic [2:0]        state, state_next;
    logic              frame_clk, frame_clk_d, start;
    logic [SNAP_W-1:0] snap, snap_next;
    logic [WORK_W-1:0] work, work_next, work_step;
    logic [CNT_W-1:0]  cnt, cnt_next;
    logic [19:0]       score_hold, score_hold_next;
    logic [11:0]       level_hold, level_hold_next;
    logic [11:0]       lives_hold, lives_hold_next;
    logic [19:0]       score_bcd_next;
    logic [11:0]       level_bcd_next, lives_bcd_next;
    logic [2:0]        score_digits_next;
    logic              bcd_valid_next, update_pulse_next, busy_next;

    // One add-3 correction pass over every digit, then shift in the next binary bit.
    function automatic logic [WORK_W-1:0] dabble(input logic [WORK_W-1:0] w, input logic b);
        logic [WORK_W-1:0] a;
        a = w;
        for (int i = 0; i < 5; i++) begin
            if (a[4*i +: 4] >= 4'd5) a[4*i +: 4] = a[4*i +: 4] + 4'd3;
        end
        return {a[WORK_W-2:0], b};
    endfunction

    function automatic logic [2:0] sig_digits(input logic [19:0] bcd);
        logic [2:0] n;
        n = 3'd1;
        for (int i = 1; i < 5; i++) begin
            if (bcd[4*i +: 4] != 4'd0) n = 3'(i + 1);
        end
        return n;
    endfunction

    assign frame_clk = (DrawX == 10'd0) && (DrawY == 10'd0);
    assign start     = frame_clk & ~frame_clk_d;
    assign work_step = dabble(work, snap[SNAP_W-1]);

    always_ff @(posedge Clk) begin
        if (!Reset_n) begin
            state        <= S_IDLE;
            frame_clk_d  <= 1'b0;
            snap         <= '0;
            work         <= '0;
            cnt          <= '0;
            score_hold   <= '0;
            level_hold   <= '0;
            lives_hold   <= '0;
            ScoreBCD     <= '0;
            LevelBCD     <= '0;
            LivesBCD     <= '0;
            ScoreDigits  <= '0;
            bcd_valid    <= 1'b0;
            update_pulse <= 1'b0;
            busy         <= 1'b0;
        end else begin
            state        <= state_next;
            frame_clk_d  <= frame_clk;
            snap         <= snap_next;
            work         <= work_next;
            cnt          <= cnt_next;
            score_hold   <= score_hold_next;
            level_hold   <= level_hold_next;
            lives_hold   <= lives_hold_next;
            ScoreBCD     <= score_bcd_next;
            LevelBCD     <= level_bcd_next;
            LivesBCD     <= lives_bcd_next;
            ScoreDigits  <= score_digits_next;
            bcd_valid    <= bcd_valid_next;
            update_pulse <= update_pulse_next;
            busy         <= busy_next;
        end
    end

    // Snapshot is one {Score,Level,Lives} shift register drained MSB-first across all three phases.
    always_comb begin
        state_next        = state;
        snap_next         = snap;
        work_next         = work;
        cnt_next          = cnt;
        score_hold_next   = score_hold;
        level_hold_next   = level_hold;
        lives_hold_next   = lives_hold;
        score_bcd_next    = ScoreBCD;
        level_bcd_next    = LevelBCD;
        lives_bcd_next    = LivesBCD;
        score_digits_next = ScoreDigits;
        bcd_valid_next    = bcd_valid;
        update_pulse_next = 1'b0;

        case (state)
            S_IDLE: begin
                if (start) begin
                    snap_next  = {Score, Level, Lives};
                    work_next  = '0;
                    cnt_next   = '0;
                    state_next = S_SCORE;
                end
            end
            S_SCORE, S_LEVEL, S_LIVES: begin
                work_next = work_step;
                snap_next = {snap[SNAP_W-2:0], 1'b0};
                cnt_next  = cnt + 4'd1;
                if (state == S_SCORE && cnt == SCORE_LAST) begin
                    score_hold_next = work_step;
                    work_next       = '0;
                    cnt_next        = '0;
                    state_next      = S_LEVEL;
                end else if (state == S_LEVEL && cnt == SHORT_LAST) begin
                    level_hold_next = work_step[11:0];
                    work_next       = '0;
                    cnt_next        = '0;
                    state_next      = S_LIVES;
                end else if (state == S_LIVES && cnt == SHORT_LAST) begin
                    lives_hold_next = work_step[11:0];
                    work_next       = '0;
                    cnt_next        = '0;
                    state_next      = S_UPDATE;
                end
            end
            S_UPDATE: begin
                score_bcd_next    = score_hold;
                level_bcd_next    = level_hold;
                lives_bcd_next    = lives_hold;
                score_digits_next = sig_digits(score_hold);
                bcd_valid_next    = 1'b1;
                update_pulse_next = 1'b1;
                state_next        = S_IDLE;
            end
            default: state_next = S_IDLE;
        endcase

        busy_next = (state_next != S_IDLE);
    end

endmodule

// File: tb/tb_hud_bcd_converter.sv
// Self-checking bench for hud_bcd_converter: directed scenarios plus random frames
// compared against a decimal-arithmetic reference model.
module tb_hud_bcd_converter;

    logic        Clk = 1'b0;
    logic        Reset_n;
    logic [9:0]  DrawX, DrawY;
    logic [15:0] Score;
    logic [7:0]  Level, Lives;
    logic [19:0] ScoreBCD;
    logic [11:0] LevelBCD, LivesBCD;
    logic [2:0]  ScoreDigits;
    logic        bcd_valid, update_pulse, busy;

    int vectors = 0;
    int miscompares = 0;
    int pulses;
    int first_pulse;
    logic busy_tr [0:39];

    hud_bcd_converter dut (
        .Clk(Clk), .Reset_n(Reset_n), .DrawX(DrawX), .DrawY(DrawY),
        .Score(Score), .Level(Level), .Lives(Lives),
        .ScoreBCD(ScoreBCD), .LevelBCD(LevelBCD), .LivesBCD(LivesBCD),
        .ScoreDigits(ScoreDigits), .bcd_valid(bcd_valid),
        .update_pulse(update_pulse), .busy(busy)
    );

    always #5 Clk = ~Clk;

    // Reference: decimal digits by repeated division.
    function automatic logic [19:0] ref_bcd(input int unsigned v);
        logic [19:0] r;
        int unsigned x;
        r = '0;
        x = v;
        for (int i = 0; i < 5; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic int ref_digits(input int unsigned v);
        int n;
        int unsigned x;
        n = 1;
        x = v;
        while (x >= 10) begin
            x = x / 10;
            n++;
        end
        return n;
    endfunction

    // Strobe a frame, then observe 40 cycles; n counts negedges after the capture edge.
    // act_kind 1: change Score at n=act_n; act_kind 2: also re-strobe at n=act_n.
    task automatic convert(input logic [15:0] s, input logic [7:0] l, input logic [7:0] v,
                           input int act_n, input int act_kind, input logic [15:0] act_score);
        Score = s; Level = l; Lives = v;
        @(negedge Clk);
        DrawX = 10'd0; DrawY = 10'd0;
        @(negedge Clk);
        DrawX = 10'd5; DrawY = 10'd7;
        pulses = 0;
        first_pulse = -1;
        for (int n = 0; n < 40; n++) begin
            if (n > 0) @(negedge Clk);
            busy_tr[n] = busy;
            if (update_pulse) begin
                pulses++;
                if (first_pulse < 0) first_pulse = n;
            end
            if (act_kind != 0 && n == act_n) begin
                Score = act_score;
                if (act_kind == 2) begin DrawX = 10'd0; DrawY = 10'd0; end
            end
            if (act_kind == 2 && n == act_n + 1) begin DrawX = 10'd5; DrawY = 10'd7; end
        end
    endtask

    task automatic test_reset();
        Reset_n = 1'b0; Score = 16'd1234; Level = 8'd0; Lives = 8'd0;
        DrawX = 10'd5; DrawY = 10'd7;
        repeat (3) @(negedge Clk);
        Reset_n = 1'b1;
        repeat (4) @(negedge Clk);
        if ({ScoreBCD, LevelBCD, LivesBCD} !== 44'd0) begin
            miscompares++; $display("FAIL reset_bcd got %h want 0", {ScoreBCD, LevelBCD, LivesBCD});
        end
        vectors++;
        if ({ScoreDigits, bcd_valid, update_pulse, busy} !== 6'd0) begin
            miscompares++;
            $display("FAIL reset_flags got digits=%0d valid=%b pulse=%b busy=%b want all 0",
                     ScoreDigits, bcd_valid, update_pulse, busy);
        end
        vectors++;
    endtask

    task automatic test_basic();
        convert(16'd65535, 8'd10, 8'd3, -1, 0, 16'd0);
        if (first_pulse !== 33) begin
            miscompares++; $display("FAIL basic_latency got %0d want 33", first_pulse);
        end
        vectors++;
        if (pulses !== 1) begin
            miscompares++; $display("FAIL basic_pulse_count got %0d want 1", pulses);
        end
        vectors++;
        if (busy_tr[0] !== 1'b1 || busy_tr[32] !== 1'b1 || busy_tr[33] !== 1'b0) begin
            miscompares++;
            $display("FAIL basic_busy got n0=%b n32=%b n33=%b want 1 1 0", busy_tr[0], busy_tr[32], busy_tr[33]);
        end
        vectors++;
        if (ScoreBCD !== 20'h65535 || LevelBCD !== 12'h010 || LivesBCD !== 12'h003) begin
            miscompares++;
            $display("FAIL basic_bcd got %h %h %h want 65535 010 003", ScoreBCD, LevelBCD, LivesBCD);
        end
        vectors++;
        if (ScoreDigits !== 3'd5 || bcd_valid !== 1'b1) begin
            miscompares++; $display("FAIL basic_digits got %0d valid=%b want 5 1", ScoreDigits, bcd_valid);
        end
        vectors++;
    endtask

    task automatic test_zero_wrap();
        convert(16'd0, 8'd1, 8'hFF, -1, 0, 16'd0);
        if (ScoreBCD !== 20'h00000 || ScoreDigits !== 3'd1) begin
            miscompares++; $display("FAIL zero_score got %h/%0d want 00000/1", ScoreBCD, ScoreDigits);
        end
        vectors++;
        if (LevelBCD !== 12'h001 || LivesBCD !== 12'h255) begin
            miscompares++; $display("FAIL wrap_level_lives got %h %h want 001 255", LevelBCD, LivesBCD);
        end
        vectors++;
    endtask

    task automatic test_snapshot();
        convert(16'd100, 8'd2, 8'd4, 4, 1, 16'd9999);
        if (ScoreBCD !== 20'h00100 || ScoreDigits !== 3'd3) begin
            miscompares++; $display("FAIL snapshot_iso got %h/%0d want 00100/3", ScoreBCD, ScoreDigits);
        end
        vectors++;
        convert(16'd9999, 8'd2, 8'd4, -1, 0, 16'd0);
        if (ScoreBCD !== 20'h09999 || ScoreDigits !== 3'd4) begin
            miscompares++; $display("FAIL snapshot_next got %h/%0d want 09999/4", ScoreBCD, ScoreDigits);
        end
        vectors++;
    endtask

    task automatic test_back_to_back();
        convert(16'd4321, 8'd77, 8'd9, 9, 2, 16'd8);
        if (ScoreBCD !== 20'h04321 || LevelBCD !== 12'h077 || LivesBCD !== 12'h009) begin
            miscompares++;
            $display("FAIL restrobe_result got %h %h %h want 04321 077 009", ScoreBCD, LevelBCD, LivesBCD);
        end
        vectors++;
        if (pulses !== 1 || first_pulse !== 33) begin
            miscompares++; $display("FAIL restrobe_pulse got count=%0d at=%0d want 1 at 33", pulses, first_pulse);
        end
        vectors++;
    endtask

    task automatic test_reset_mid();
        int late;
        Score = 16'd555; Level = 8'd6; Lives = 8'd7;
        @(negedge Clk);
        DrawX = 10'd0; DrawY = 10'd0;
        @(negedge Clk);
        DrawX = 10'd5; DrawY = 10'd7;
        repeat (19) @(negedge Clk);
        Reset_n = 1'b0;
        @(negedge Clk);
        Reset_n = 1'b1;
        if ({ScoreBCD, LevelBCD, LivesBCD, ScoreDigits} !== 47'd0 || bcd_valid !== 1'b0 || busy !== 1'b0) begin
            miscompares++;
            $display("FAIL midreset_clear got %h %h %h d=%0d valid=%b busy=%b want all 0",
                     ScoreBCD, LevelBCD, LivesBCD, ScoreDigits, bcd_valid, busy);
        end
        vectors++;
        late = 0;
        for (int n = 0; n < 40; n++) begin
            @(negedge Clk);
            if (update_pulse) late++;
        end
        if (late !== 0 || bcd_valid !== 1'b0) begin
            miscompares++; $display("FAIL midreset_no_pulse got pulses=%0d valid=%b want 0 0", late, bcd_valid);
        end
        vectors++;
        convert(16'd31337, 8'd200, 8'd0, -1, 0, 16'd0);
        if (ScoreBCD !== 20'h31337 || LevelBCD !== 12'h200 || LivesBCD !== 12'h000 || bcd_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL midreset_recover got %h %h %h valid=%b want 31337 200 000 1",
                     ScoreBCD, LevelBCD, LivesBCD, bcd_valid);
        end
        vectors++;
    endtask

    task automatic test_random();
        logic [15:0] s;
        logic [7:0]  l, v;
        for (int k = 0; k < 10; k++) begin
            s = 16'($urandom);
            l = 8'($urandom);
            v = 8'($urandom);
            convert(s, l, v, -1, 0, 16'd0);
            if (ScoreBCD !== ref_bcd(32'(s)) || LevelBCD !== 12'(ref_bcd(32'(l)))
                || LivesBCD !== 12'(ref_bcd(32'(v)))) begin
                miscompares++;
                $display("FAIL random_bcd in=%0d/%0d/%0d got %h %h %h want %h %h %h", s, l, v,
                         ScoreBCD, LevelBCD, LivesBCD, ref_bcd(32'(s)),
                         12'(ref_bcd(32'(l))), 12'(ref_bcd(32'(v))));
            end
            vectors++;
            if (ScoreDigits !== 3'(ref_digits(32'(s))) || first_pulse !== 33 || pulses !== 1) begin
                miscompares++;
                $display("FAIL random_digits in=%0d got d=%0d at=%0d cnt=%0d want d=%0d at=33 cnt=1",
                         s, ScoreDigits, first_pulse, pulses, ref_digits(32'(s)));
            end
            vectors++;
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_zero_wrap();
        test_snapshot();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/hud_bcd_converter.md
# hud_bcd_converter

Sequential binary-to-BCD converter sitting directly downstream of the game-logic top level. Once per video frame it snapshots the binary `Score`, `Level` and `Lives` values produced by the game core and converts them to packed BCD digits with an iterative shift-add-3 (double-dabble) engine. The HUD text renderer consumes these digits. Outputs hold stable for the whole frame and update atomically.

## Interface
Parameters: none.

Ports:
- `Clk` in 1: system/pixel clock, same clock as the game core.
- `Reset_n` in 1: reset, synchronous, active-low.
- `DrawX` in 10: current pixel X from the VGA controller.
- `DrawY` in 10: current pixel Y from the VGA controller.
- `Score` in 16: binary score from the game core.
- `Level` in 8: binary level from the game core.
- `Lives` in 8: binary lives from the game core.
- `ScoreBCD` out 20: 5 BCD digits; [19:16] is the ten-thousands digit.
- `LevelBCD` out 12: 3 BCD digits; [11:8] is the hundreds digit.
- `LivesBCD` out 12: 3 BCD digits.
- `ScoreDigits` out 3: count of significant score digits, 1..5, used for leading-zero blanking.
- `bcd_valid` out 1: high once the first conversion after reset has completed.
- `update_pulse` out 1: one-cycle strobe when the outputs change.
- `busy` out 1: high while a conversion is in progress.

## Operation
- **Frame strobe.**
  - `frame_clk = (DrawX==0 && DrawY==0)`.
  - `frame_clk_d` is registered from `frame_clk`.
  - `start = frame_clk & ~frame_clk_d`, combinational.
- **FSM states:** IDLE, SCORE, LEVEL, LIVES, UPDATE.
- **IDLE.**
  - If `start` is high: capture `Score`, `Level`, `Lives` into internal snapshot registers.
  - Clear the BCD working register and the iteration counter, then go to SCORE.
- **SCORE.**
  - 16 iterations, one per cycle.
  - Each iteration: for every 4-bit digit of the 20-bit working register, if digit ≥ 5 add 3. Then shift {work, snapshot} left by 1, taking the MSB of the snapshot.
  - After the 16th iteration: store the result into an internal score holding register, clear the working register, go to LEVEL.
- **LEVEL.** Same procedure, 8 iterations, 12-bit working register. Then go to LIVES.
- **LIVES.** Same procedure, 8 iterations. Then go to UPDATE.
- **UPDATE.**
  - Load `ScoreBCD`, `LevelBCD`, `LivesBCD` and `ScoreDigits` together from the holding registers.
  - Set `bcd_valid` to 1 (sticky until reset).
  - Pulse `update_pulse` for one cycle.
  - Go to IDLE.
- **`ScoreDigits`:** index of the highest nonzero digit plus 1. A score of 0 gives 1.
- **Inputs are not range-limited.**
  - Lives = 8'hFF (underflow) displays as 0x255.
  - Score = 65535 displays as 0x65535.
- **`start` outside IDLE** is ignored. No queuing, and the snapshot is unchanged.
- **Input changes after capture** do not affect the conversion in flight.
- `busy` is high in every state except IDLE.

## Timing
- **Reset.** With `Reset_n` low at a `Clk` edge:
  - all outputs go to 0 (`ScoreBCD`, `LevelBCD`, `LivesBCD`, `ScoreDigits`, `bcd_valid`, `update_pulse`, `busy`);
  - FSM goes to IDLE;
  - `frame_clk_d` goes to 0.
- **Reset mid-conversion.** Aborts immediately: outputs are zeroed and the partial result is discarded.
- **Latency.** Let E0 be the capture edge, where `start` is high in IDLE.
  - Score iterations occur at edges E1..E16.
  - Level iterations at E17..E24.
  - Lives iterations at E25..E32.
  - Outputs, `bcd_valid` and `update_pulse` become visible after E33.
  - `update_pulse` is low again after E34.
  - `busy` is high from after E0 through E33, then low after E33.
- **Between updates** the outputs are constant. A new `start` may be accepted at E34 at the earliest.
- **Throughput.** One conversion per frame. At 640x480 the frame period far exceeds 34 cycles.

## Test plan
1. **Reset.** Hold `Reset_n`=0 for 3 cycles with Score=1234, then release without a frame strobe. Required: all outputs stay 0 and `busy`=0.
2. **Basic conversion.** Score=65535, Level=10, Lives=3, then drive DrawX=DrawY=0. Required, exactly 33 cycles after the capture edge:
   - ScoreBCD=0x65535, LevelBCD=0x010, LivesBCD=0x003;
   - ScoreDigits=5, `bcd_valid`=1;
   - `update_pulse` high for exactly 1 cycle.
3. **Zero and wrap.** Score=0, Level=1, Lives=8'hFF. Required: ScoreBCD=0x00000, ScoreDigits=1, LevelBCD=0x001, LivesBCD=0x255.
4. **Snapshot isolation.** Capture Score=100, then change Score to 9999 at E5. Required: ScoreBCD=0x00100 and ScoreDigits=3. The next frame then yields 0x09999 and ScoreDigits=4.
5. **Busy and re-strobe.** Force a second `start` at E10. Required: it is ignored, the result is from the first snapshot, and exactly one `update_pulse` occurs.
6. **Reset mid-conversion.** Assert `Reset_n`=0 at E20 after a prior valid result. Required: outputs are 0 and `bcd_valid`=0 on the next edge; no `update_pulse` follows. A subsequent frame converts normally.
